// File: rtl/sccb_request_arbiter.sv
// -----------------------------------------------------------------------------
// sccb_request_arbiter
//
// Shares one SCCB register-write interface between two requesters:
//   requester 0 - ROM-driven camera configuration sequencer
//   requester 1 - runtime register-tweak path (exposure, gain, mirror)
//
// Requests are arbitrated round-robin. Each grant issues exactly one SCCB
// register write. The block then follows the SCCB master's ready handshake
// until the write completes. After every transaction, completed or timed out,
// a fixed idle gap is enforced. Watchdogs cover two failures: a master that
// never accepts the start, and a master that never finishes the write.
//
// Ports
//   clk                   system clock, all logic on the rising edge
//   rst                   synchronous, active-high reset
//   reqN_valid            requester N has a write pending, held until reqN_ack
//   reqN_addr/reqN_data   register address / data of requester N
//   reqN_ack              1-cycle pulse, request accepted (inputs may change)
//   reqN_done             1-cycle pulse, transaction of requester N finished
//   reqN_err              qualifies reqN_done: 1 = timeout
//   SCCB_interface_ready  SCCB master idle / ready
//   SCCB_interface_start  1-cycle start pulse to the SCCB master
//   SCCB_interface_addr   register address to the SCCB master
//   SCCB_interface_data   register data to the SCCB master
//   busy                  1 whenever the arbiter is not idle
//   grant_id              owner of the current or most recent transaction
//
// Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module sccb_request_arbiter #(
    parameter int CLK_FREQ      = 25000000,
    parameter int START_TIMEOUT = 16,
    parameter int TXN_TIMEOUT   = CLK_FREQ / 100,
    parameter int GAP_CYCLES    = 4
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       req0_valid,
    input  logic [7:0] req0_addr,
    input  logic [7:0] req0_data,
    output logic       req0_ack,
    output logic       req0_done,
    output logic       req0_err,

    input  logic       req1_valid,
    input  logic [7:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       req1_ack,
    output logic       req1_done,
    output logic       req1_err,

    input  logic       SCCB_interface_ready,
    output logic       SCCB_interface_start,
    output logic [7:0] SCCB_interface_addr,
    output logic [7:0] SCCB_interface_data,

    output logic       busy,
    output logic       grant_id
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    // Timer terminal counts. The timer is 32 bits wide, so it reaches either
    // limit before it can wrap.
    localparam logic [31:0] START_LIMIT = 32'(START_TIMEOUT - 1);
    localparam logic [31:0] TXN_LIMIT   = 32'(TXN_TIMEOUT - 1);

    // The gap counter must be able to hold GAP_CYCLES. It is at least 1 bit
    // wide so that GAP_CYCLES of 0 or 1 still give a legal vector.
    localparam int              GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

    state_t           state;
    logic [31:0]      timer;
    logic [GAP_W-1:0] gap_cnt;
    logic             last_grant;

    // Arbitration result and transaction-end decode.
    logic pick_valid;
    logic pick_id;
    logic finish;
    logic finish_err;

    // -------------------------------------------------------------------------
    // Round-robin pick. A lone requester always wins. On a tie, the requester
    // that did not own the previous grant wins.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default at the top of a combinational block
        // so that no path leaves it unassigned, which would infer a latch.
        pick_valid = req0_valid | req1_valid;
        pick_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            pick_id = ~last_grant;
        end else if (req1_valid) begin
            pick_id = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // End-of-transaction decode. A transaction ends in one of three ways:
    //   - the master never dropped ready after start (start timeout)
    //   - ready re-rose (normal completion)
    //   - ready stayed low too long (transaction timeout)
    // -------------------------------------------------------------------------
    always_comb begin
        finish     = 1'b0;
        finish_err = 1'b0;
        case (state)
            WAIT_BUSY: begin
                if (SCCB_interface_ready && (timer == START_LIMIT)) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (SCCB_interface_ready) begin
                    finish = 1'b1;
                end else if (timer == TXN_LIMIT) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Main FSM with registered outputs.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every flop then
    // samples the values from before the clock edge, independent of the order
    // of statements in the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            // A reset does not abort a write already in flight at the SCCB
            // master. IDLE only issues when ready is high, which covers that.
            state                <= IDLE;
            timer                <= '0;
            gap_cnt              <= '0;
            last_grant           <= 1'b1;   // makes req0 win the first tie
            grant_id             <= 1'b0;
            busy                 <= 1'b0;
            SCCB_interface_start <= 1'b0;
            SCCB_interface_addr  <= '0;
            SCCB_interface_data  <= '0;
            req0_ack             <= 1'b0;
            req1_ack             <= 1'b0;
            req0_done            <= 1'b0;
            req1_done            <= 1'b0;
            req0_err             <= 1'b0;
            req1_err             <= 1'b0;
        end else begin
            // Pulse outputs fall back to 0 unless a branch below raises them.
            SCCB_interface_start <= 1'b0;
            req0_ack             <= 1'b0;
            req1_ack             <= 1'b0;
            req0_done            <= 1'b0;
            req1_done            <= 1'b0;
            req0_err             <= 1'b0;
            req1_err             <= 1'b0;

            case (state)
                IDLE: begin
                    if (SCCB_interface_ready && pick_valid) begin
                        SCCB_interface_start <= 1'b1;
                        SCCB_interface_addr  <= pick_id ? req1_addr : req0_addr;
                        SCCB_interface_data  <= pick_id ? req1_data : req0_data;
                        req0_ack             <= ~pick_id;
                        req1_ack             <= pick_id;
                        grant_id             <= pick_id;
                        last_grant           <= pick_id;
                        timer                <= '0;
                        busy                 <= 1'b1;
                        state                <= WAIT_BUSY;
                    end
                end

                WAIT_BUSY: begin
                    if (!SCCB_interface_ready) begin
                        // The master has taken the write. Restart the timer
                        // to watch the write itself.
                        timer <= '0;
                        state <= WAIT_DONE;
                    end else if (!finish) begin
                        timer <= timer + 32'd1;
                    end
                end

                WAIT_DONE: begin
                    if (!finish) begin
                        timer <= timer + 32'd1;
                    end
                end

                GAP: begin
                    if (gap_cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase

            // A transaction has ended. Report the result only to the owner,
            // then start the idle gap.
            if (finish) begin
                req0_done <= ~grant_id;
                req1_done <= grant_id;
                req0_err  <= ~grant_id & finish_err;
                req1_err  <= grant_id & finish_err;
                gap_cnt   <= GAP_LOAD;
                state     <= GAP;
            end
        end
    end

endmodule

// File: tb/tb_sccb_request_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sccb_request_arbiter
//
// Directed testbench for sccb_request_arbiter. Parameters: START_TIMEOUT=16,
// TXN_TIMEOUT=100, GAP_CYCLES=4. Inputs change and outputs are sampled 1 ns
// after each rising edge. Expected values are hand-derived cycle counts.
// -----------------------------------------------------------------------------
module tb_sccb_request_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_addr, req0_data, req1_addr, req1_data;
    logic       req0_ack, req0_done, req0_err;
    logic       req1_ack, req1_done, req1_err;
    logic       ready;
    logic       start;
    logic [7:0] sccb_addr, sccb_data;
    logic       busy, grant_id;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sccb_request_arbiter #(
        .CLK_FREQ      (25000000),
        .START_TIMEOUT (16),
        .TXN_TIMEOUT   (100),
        .GAP_CYCLES    (4)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req0_valid           (req0_valid),
        .req0_addr            (req0_addr),
        .req0_data            (req0_data),
        .req0_ack             (req0_ack),
        .req0_done            (req0_done),
        .req0_err             (req0_err),
        .req1_valid           (req1_valid),
        .req1_addr            (req1_addr),
        .req1_data            (req1_data),
        .req1_ack             (req1_ack),
        .req1_done            (req1_done),
        .req1_err             (req1_err),
        .SCCB_interface_ready (ready),
        .SCCB_interface_start (start),
        .SCCB_interface_addr  (sccb_addr),
        .SCCB_interface_data  (sccb_data),
        .busy                 (busy),
        .grant_id             (grant_id)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks an issue cycle: start pulse, ack to id only, latched addr/data.
    task automatic check_issue(input string tag, input logic id,
                               input logic [7:0] a, input logic [7:0] d);
        check({tag, "_start"}, start, 1'b1);
        check({tag, "_ack0"}, req0_ack, ~id);
        check({tag, "_ack1"}, req1_ack, id);
        check({tag, "_grant"}, grant_id, id);
        check({tag, "_busy"}, busy, 1'b1);
        check_byte({tag, "_addr"}, sccb_addr, a);
        check_byte({tag, "_data"}, sccb_data, d);
    endtask

    // Starts just after an issue edge. The master drops ready for one cycle,
    // then raises it. Checks the done pulse and the return to idle after the
    // gap.
    task automatic run_txn(input string tag, input logic id);
        tick();                 // WAIT_BUSY, ready still 1
        check({tag, "_start_pulse"}, start, 1'b0);
        ready = 1'b0;
        tick();                 // -> WAIT_DONE
        ready = 1'b1;
        tick();                 // ready re-rose -> done
        check({tag, "_done0"}, req0_done, ~id);
        check({tag, "_done1"}, req1_done, id);
        check({tag, "_err"}, req0_err | req1_err, 1'b0);
        ticks(5);               // GAP of GAP_CYCLES+1 cycles
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_addr = 8'h00; req0_data = 8'h00;
        req1_valid = 1'b0; req1_addr = 8'h00; req1_data = 8'h00;
        ready = 1'b1;
        ticks(2);
        rst = 1'b0;

        // ---- reset state ----
        check("rst_start", start, 1'b0);
        check("rst_ack", req0_ack | req1_ack, 1'b0);
        check("rst_done", req0_done | req1_done, 1'b0);
        check("rst_err", req0_err | req1_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_grant", grant_id, 1'b0);
        check_byte("rst_addr", sccb_addr, 8'h00);
        check_byte("rst_data", sccb_data, 8'h00);

        // ---- single request, ready low for 3 cycles ----
        req0_valid = 1'b1; req0_addr = 8'h12; req0_data = 8'h80;
        tick();
        check_issue("single", 1'b0, 8'h12, 8'h80);
        req0_valid = 1'b0;
        tick();
        check("single_ack_pulse", req0_ack, 1'b0);
        ready = 1'b0;
        ticks(3);
        check("single_no_early_done", req0_done, 1'b0);
        ready = 1'b1;
        tick();
        check("single_done", req0_done, 1'b1);
        check("single_err", req0_err, 1'b0);
        check("single_done1", req1_done, 1'b0);
        tick();
        check("single_done_pulse", req0_done, 1'b0);
        check("single_gap_busy", busy, 1'b1);
        ticks(3);
        check("single_gap_busy_last", busy, 1'b1);
        tick();
        check("single_idle", busy, 1'b0);
        check_byte("single_addr_hold", sccb_addr, 8'h12);

        // ---- contention from reset: order 0,1,0,1 ----
        rst = 1'b1;
        req0_valid = 1'b1; req0_addr = 8'h21; req0_data = 8'h01;
        req1_valid = 1'b1; req1_addr = 8'h31; req1_data = 8'h11;
        tick();
        rst = 1'b0;
        tick();
        check_issue("rr0", 1'b0, 8'h21, 8'h01);
        run_txn("rr0", 1'b0);
        tick();
        check_issue("rr1", 1'b1, 8'h31, 8'h11);
        run_txn("rr1", 1'b1);
        tick();
        check_issue("rr2", 1'b0, 8'h21, 8'h01);
        run_txn("rr2", 1'b0);
        tick();
        check_issue("rr3", 1'b1, 8'h31, 8'h11);
        run_txn("rr3", 1'b1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // ---- start timeout: ready never falls ----
        req0_valid = 1'b1; req0_addr = 8'h40; req0_data = 8'h55;
        tick();
        check_issue("sto", 1'b0, 8'h40, 8'h55);
        req0_valid = 1'b0;
        ticks(15);
        check("sto_not_yet", req0_done, 1'b0);
        tick();
        check("sto_done", req0_done, 1'b1);
        check("sto_err", req0_err, 1'b1);
        check("sto_done1", req1_done, 1'b0);
        check("sto_busy", busy, 1'b1);
        ticks(5);
        check("sto_idle", busy, 1'b0);

        // ---- transaction timeout: ready falls and stays low ----
        req1_valid = 1'b1; req1_addr = 8'h50; req1_data = 8'h66;
        tick();
        check_issue("tto", 1'b1, 8'h50, 8'h66);
        req1_valid = 1'b0;
        ready = 1'b0;
        tick();                 // first WAIT_DONE cycle
        ticks(99);
        check("tto_not_yet", req1_done, 1'b0);
        tick();
        check("tto_done", req1_done, 1'b1);
        check("tto_err", req1_err, 1'b1);
        check("tto_done0", req0_done, 1'b0);
        // The next request waits in IDLE while ready is still low.
        req0_valid = 1'b1; req0_addr = 8'h60; req0_data = 8'h77;
        ticks(8);
        check("tto_hold_start", start, 1'b0);
        check("tto_hold_ack", req0_ack, 1'b0);
        check("tto_hold_busy", busy, 1'b0);
        ready = 1'b1;
        tick();
        check_issue("tto_next", 1'b0, 8'h60, 8'h77);
        req0_valid = 1'b0;
        run_txn("tto_next", 1'b0);

        // ---- not-ready gating on requester 1 ----
        ready = 1'b0;
        req1_valid = 1'b1; req1_addr = 8'h70; req1_data = 8'h88;
        ticks(3);
        check("gate_start", start, 1'b0);
        check("gate_ack", req1_ack, 1'b0);
        ready = 1'b1;
        tick();
        check_issue("gate", 1'b1, 8'h70, 8'h88);
        req1_valid = 1'b0;

        // ---- reset in WAIT_DONE ----
        tick();
        ready = 1'b0;
        ticks(2);               // now in WAIT_DONE
        rst = 1'b1;
        req0_valid = 1'b1; req0_addr = 8'h99; req0_data = 8'hAA;
        tick();
        rst = 1'b0;
        check("mrst_start", start, 1'b0);
        check("mrst_ack", req0_ack | req1_ack, 1'b0);
        check("mrst_done", req0_done | req1_done, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_grant", grant_id, 1'b0);
        check_byte("mrst_addr", sccb_addr, 8'h00);
        ticks(3);
        check("mrst_hold_start", start, 1'b0);
        check("mrst_hold_done", req1_done, 1'b0);
        check("mrst_hold_busy", busy, 1'b0);
        ready = 1'b1;
        tick();
        check_issue("mrst_next", 1'b0, 8'h99, 8'hAA);
        req0_valid = 1'b0;
        run_txn("mrst_next", 1'b0);

        // ---- withdrawn request: valid drops before ready ----
        ready = 1'b0;
        req1_valid = 1'b1; req1_addr = 8'hC3; req1_data = 8'h3C;
        ticks(2);
        req1_valid = 1'b0;
        ready = 1'b1;
        ticks(2);
        check("wd_start", start, 1'b0);
        check("wd_busy", busy, 1'b0);
        check_byte("wd_addr", sccb_addr, 8'h99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sccb_request_arbiter.md
Name: sccb_request_arbiter

Overview:
Shares the single SCCB write interface between two requesters: requester 0 is the ROM-driven camera configuration sequencer, requester 1 is the runtime register-tweak path (exposure, gain, mirror). The block arbitrates round-robin, issues one SCCB register write per grant and tracks the ready handshake to completion. It also enforces an inter-transaction gap and watchdog timeouts. It sits between both requesters and the SCCB master.

Parameters:
CLK_FREQ, 25000000, system clock frequency in Hz
START_TIMEOUT, 16, maximum cycles after start for SCCB_interface_ready to fall
TXN_TIMEOUT, CLK_FREQ/100, maximum cycles ready may stay low (10 ms)
GAP_CYCLES, 4, idle cycles enforced after each completed or failed transaction

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has a write pending; held until req0_ack
req0_addr  in  8  requester 0 register address
req0_data  in  8  requester 0 register data
req0_ack  out  1  one-cycle pulse: request 0 accepted, inputs may change
req0_done  out  1  one-cycle pulse: request 0 transaction finished
req0_err  out  1  valid with req0_done; 1 = timeout
req1_valid, req1_addr, req1_data, req1_ack, req1_done, req1_err  same as requester 0, for requester 1
SCCB_interface_ready  in  1  SCCB master idle/ready
SCCB_interface_start  out  1  one-cycle start pulse to SCCB master
SCCB_interface_addr  out  8  register address to SCCB master
SCCB_interface_data  out  8  register data to SCCB master
busy  out  1  1 in any state other than IDLE
grant_id  out  1  requester owning the current or most recent transaction

Behaviour:
- Reset: all outputs 0; state IDLE; last_grant=1, so req0 wins the first tie; counters 0. Reset mid-transaction does not abort the SCCB master; IDLE waits for ready=1 before issuing again.
- States: IDLE, WAIT_BUSY, WAIT_DONE, GAP. All outputs are registered.
- IDLE: when ready=1 and any reqN_valid=1, select a winner.
  - Selection: only one requester valid -> that one. Both valid -> the requester that is not last_grant.
  - Next cycle: SCCB_interface_start=1; addr/data latched from the winner; reqN_ack=1; grant_id and last_grant updated; timer=0; state -> WAIT_BUSY.
  - valid with ready=0 -> stay IDLE, no ack.
- WAIT_BUSY: start=0 and ack=0, both single-cycle.
  - ready=0 -> timer=0, state -> WAIT_DONE.
  - Otherwise timer+1. When timer reaches START_TIMEOUT-1 with ready still 1 -> reqN_done=1 and reqN_err=1 for one cycle, state -> GAP.
- WAIT_DONE:
  - ready=1 -> reqN_done=1, reqN_err=0, state -> GAP.
  - Otherwise timer+1. When timer reaches TXN_TIMEOUT-1 -> done+err pulse, state -> GAP.
- GAP: counter loaded with GAP_CYCLES on entry; decrements each cycle; at 0 -> IDLE. GAP_CYCLES=0 -> IDLE on the cycle after entry.
- Latency: valid (ready=1) to start is 1 cycle. Done occurs 1 cycle after ready re-rises.
- Inputs of the non-granted requester are ignored until IDLE. A requester deasserting valid before ack withdraws its request; no ack or done is issued.
- done/err go only to grant_id's requester. ack/done are never asserted to both requesters in one cycle.
- SCCB_interface_addr/data hold their last value outside an issue.
- Timer is 32-bit and never wraps within the timeouts.

Test Plan:
- Single request: req0 valid addr=0x12 data=0x80, ready=1 -> start and req0_ack at cycle+1 with addr 0x12/data 0x80. Ready low 3 cycles then high -> req0_done=1, err=0; busy low after GAP_CYCLES+1 cycles.
- Contention: both valid from reset -> req0 granted first. req1 granted on the next IDLE (grant_id=1). Both held valid again -> order alternates 0,1,0,1 over 4 transactions.
- Start timeout: grant issued, ready held 1 -> after START_TIMEOUT cycles reqN_done=1, reqN_err=1; state passes GAP then IDLE.
- Transaction timeout with TXN_TIMEOUT=100: ready falls and stays low -> done+err at cycle 100 of WAIT_DONE. Next request waits in IDLE until ready=1.
- Not-ready gating: req1 valid while ready=0 -> no start and no ack. Ready rises -> start on the following cycle.
- Mid-transaction reset: rst in WAIT_DONE -> all outputs 0 next cycle, no done pulse. With ready still low, pending valid is not issued until ready=1.
